// File: rtl/sipo_deframer.sv
// Serial-in / parallel-out receive deframer: assembles WIDTH-bit MSB-first words
// aligned by frame_start and presents them on a valid/ready output register.
module sipo_deframer #(
  parameter int WIDTH      = 4,
  parameter bit CONTINUOUS = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             bit_en,
  input  logic             frame_start,
  input  logic             out_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             overrun,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  // Only the first WIDTH-1 bits need storing; the last bit comes straight from serial_in.
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             ferr_q, ferr_d;

  logic [WIDTH-1:0] ext;
  logic             complete;

  assign ext = {shift_q, serial_in};

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    ferr_d    = 1'b0;
    complete  = 1'b0;

    if (bit_en) begin
      if (frame_start) begin
        if (state_q == SHIFT && cnt_q != '0) ferr_d = 1'b1;
        shift_d    = '0;
        shift_d[0] = serial_in;
        cnt_d      = CW'(1);
        state_d    = SHIFT;
      end else if (state_q == SHIFT) begin
        if (cnt_q == CNT_LAST) begin
          complete = 1'b1;
          cnt_d    = '0;
          state_d  = CONTINUOUS ? SHIFT : IDLE;
        end else begin
          shift_d = ext[WIDTH-2:0];
          cnt_d   = cnt_q + CW'(1);
        end
      end
    end

    if (overrun_clr) overrun_d = 1'b0;

    // Clear is applied first so a same-edge drop still leaves overrun set.
    if (complete) begin
      if (!valid_q || out_ready) begin
        data_d  = ext;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q == SHIFT) && (cnt_q != '0);

endmodule
